// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder: samples a 4-bit Johnson counter, decodes its phase,
// tracks sequence integrity with a SEARCH/TRACK/LOCKED/FAULT FSM and counts
// completed revolutions while locked.
module johnson_phase_decoder #(
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned REV_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [3:0]           q_i,
    input  logic                 clr_err_i,
    output logic [2:0]           phase_o,
    output logic [7:0]           phase_onehot_o,
    output logic                 valid_o,
    output logic                 locked_o,
    output logic                 err_sticky_o,
    output logic [REV_WIDTH-1:0] rev_count_o,
    output logic                 rev_pulse_o
);

    localparam int RUN_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);

    // Legal Johnson codes indexed by phase.
    localparam logic [3:0] JCODE [0:7] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_TRACK,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    logic [3:0]           s_q, p_q;
    logic                 s_vld_q;
    logic [7:0]           s_match, p_match;
    logic                 s_legal, p_legal;
    logic [2:0]           s_idx;
    logic                 is_succ, is_hold, is_bad;

    logic [2:0]           phase_q;
    logic [7:0]           onehot_q;
    logic                 valid_q;

    state_t               state_q, state_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic                 err_q, err_d;
    logic [REV_WIDTH-1:0] rev_q, rev_d;
    logic                 pulse_q, pulse_d;

    // Stage 1: current and previous sample; s_vld_q marks that s_q holds a
    // real sample rather than the reset value.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s_q     <= 4'b0000;
            p_q     <= 4'b0000;
            s_vld_q <= 1'b0;
        end else begin
            s_q     <= q_i;
            p_q     <= s_q;
            s_vld_q <= 1'b1;
        end
    end

    // Per-phase code matches for both samples.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_match
            assign s_match[gi] = (s_q == JCODE[gi]);
            assign p_match[gi] = (p_q == JCODE[gi]);
        end
    endgenerate

    assign s_legal = |s_match;
    assign p_legal = |p_match;

    // Encode the one-hot match of the current sample into a phase index.
    always_comb begin
        s_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s_match[i]) begin
                s_idx = s_idx | 3'(i);
            end
        end
    end

    // Transition class of (p_q, s_q); successor shifts up and inverts bit 3 into bit 0.
    assign is_succ = p_legal && s_legal && (s_q == {p_q[2:0], ~p_q[3]});
    assign is_hold = p_legal && s_legal && (s_q == p_q);
    assign is_bad  = !(is_succ || is_hold);

    // Stage 2: registered decode; phase holds across illegal codes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q  <= 3'd0;
            onehot_q <= 8'h00;
            valid_q  <= 1'b0;
        end else if (s_vld_q) begin
            valid_q  <= s_legal;
            onehot_q <= s_match;
            if (s_legal) begin
                phase_q <= s_idx;
            end
        end
    end

    // Lock FSM next-state, run counter, sticky error and revolution counter.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        err_d   = err_q;
        rev_d   = rev_q;
        pulse_d = 1'b0;
        if (clr_err_i) begin
            err_d = 1'b0;
        end
        case (state_q)
            ST_SEARCH: begin
                if (s_vld_q && s_legal) begin
                    state_d = ST_TRACK;
                    run_d   = '0;
                end
            end
            ST_TRACK: begin
                if (is_succ) begin
                    if (run_q == RUN_LAST) begin
                        state_d = ST_LOCKED;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end else if (is_bad) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (is_bad) begin
                    // Error takes priority over a simultaneous clr_err.
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                end else if (is_succ && (p_q == 4'b1000)) begin
                    rev_d   = rev_q + REV_WIDTH'(1);
                    pulse_d = 1'b1;
                end
            end
            ST_FAULT: begin
                if (clr_err_i) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // FSM and counter state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_SEARCH;
            run_q   <= '0;
            err_q   <= 1'b0;
            rev_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            err_q   <= err_d;
            rev_q   <= rev_d;
            pulse_q <= pulse_d;
        end
    end

    assign phase_o        = phase_q;
    assign phase_onehot_o = onehot_q;
    assign valid_o        = valid_q;
    assign locked_o       = (state_q == ST_LOCKED);
    assign err_sticky_o   = err_q;
    assign rev_count_o    = rev_q;
    assign rev_pulse_o    = pulse_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder: directed table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_johnson_phase_decoder;

    localparam int LC = 8;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [3:0]    q_i;
    logic          clr_err_i;
    logic [2:0]    phase_o;
    logic [7:0]    phase_onehot_o;
    logic          valid_o;
    logic          locked_o;
    logic          err_sticky_o;
    logic [RW-1:0] rev_count_o;
    logic          rev_pulse_o;

    johnson_phase_decoder #(.LOCK_COUNT(LC), .REV_WIDTH(RW)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .q_i            (q_i),
        .clr_err_i      (clr_err_i),
        .phase_o        (phase_o),
        .phase_onehot_o (phase_onehot_o),
        .valid_o        (valid_o),
        .locked_o       (locked_o),
        .err_sticky_o   (err_sticky_o),
        .rev_count_o    (rev_count_o),
        .rev_pulse_o    (rev_pulse_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (mode: 0 search, 1 track, 2 locked, 3 fault).
    int         m_nsamp;
    logic [3:0] m_s, m_p;
    int         m_mode, m_run, m_rev, m_phase;
    bit         m_err, m_pulse, m_valid;
    logic [7:0] m_oh;

    typedef struct {
        logic [3:0] q;
        logic       v;
        logic [2:0] ph;
        logic [7:0] oh;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [3:0] jc(input int k);
        if (k <= 4) return 4'((1 << k) - 1);
        else        return 4'((15 << (k - 4)) & 15);
    endfunction

    // Phase of a code from its population count and bit 0; -1 if illegal.
    function automatic int code_phase(input logic [3:0] c);
        int n;
        int k;
        n = $countones(c);
        if (c[0]) k = n;
        else      k = (n == 0) ? 0 : 8 - n;
        return (jc(k) == c) ? k : -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_nsamp = 0; m_s = 4'd0; m_p = 4'd0; m_mode = 0; m_run = 0;
        m_rev = 0; m_phase = 0; m_err = 0; m_pulse = 0; m_valid = 0; m_oh = 8'd0;
    endtask

    task automatic model_edge(input logic [3:0] qv, input bit clr);
        int  ps, ss, old_mode;
        bit  succ, hold, bad;
        ps = code_phase(m_p);
        ss = code_phase(m_s);
        succ = (ps >= 0) && (ss >= 0) && (ss == (ps + 1) % 8);
        hold = (ps >= 0) && (ss >= 0) && (ss == ps);
        bad  = !(succ || hold);
        if (m_nsamp >= 1) begin
            m_valid = (ss >= 0);
            m_oh    = (ss >= 0) ? 8'(1 << ss) : 8'd0;
            if (ss >= 0) m_phase = ss;
        end
        old_mode = m_mode;
        m_pulse  = 0;
        case (m_mode)
            0: if (m_nsamp >= 1 && ss >= 0) begin m_mode = 1; m_run = 0; end
            1: if (succ) begin
                   if (m_run == LC - 1) m_mode = 2; else m_run++;
               end else if (bad) m_mode = 0;
            2: if (bad) m_mode = 3;
               else if (succ && ps == 7) begin
                   m_rev = (m_rev + 1) % (1 << RW);
                   m_pulse = 1;
               end
            default: if (clr) m_mode = 0;
        endcase
        if (old_mode == 2 && bad) m_err = 1;
        else if (clr)             m_err = 0;
        m_p = m_s;
        m_s = qv;
        if (m_nsamp < 2) m_nsamp++;
    endtask

    task automatic compare_model();
        chk("phase",  32'(phase_o),        32'(m_phase));
        chk("onehot", 32'(phase_onehot_o), 32'(m_oh));
        chk("valid",  32'(valid_o),        32'(m_valid));
        chk("locked", 32'(locked_o),       32'(m_mode == 2));
        chk("err",    32'(err_sticky_o),   32'(m_err));
        chk("rev",    32'(rev_count_o),    32'(m_rev));
        chk("pulse",  32'(rev_pulse_o),    32'(m_pulse));
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, check at the next falling edge.
    task automatic step(input logic [3:0] qv, input bit clr);
        q_i = qv;
        clr_err_i = clr;
        @(posedge clk);
        model_edge(qv, clr);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        q_i = 4'd0;
        clr_err_i = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        compare_model();
        reset_i = 1'b0;
    endtask

    // Assert reset between clock edges and check outputs clear without an edge.
    task automatic async_reset_check(input string nm);
        #2;
        reset_i = 1'b1;
        #1;
        chk({nm, "_phase"},  32'(phase_o),        32'd0);
        chk({nm, "_onehot"}, 32'(phase_onehot_o), 32'd0);
        chk({nm, "_valid"},  32'(valid_o),        32'd0);
        chk({nm, "_locked"}, 32'(locked_o),       32'd0);
        chk({nm, "_err"},    32'(err_sticky_o),   32'd0);
        chk({nm, "_rev"},    32'(rev_count_o),    32'd0);
        chk({nm, "_pulse"},  32'(rev_pulse_o),    32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        int ph;
        logic [3:0] c;
        tbl[0] = '{4'b0000, 1'b0, 3'd0, 8'h00};
        tbl[1] = '{4'b0000, 1'b1, 3'd0, 8'h01};
        tbl[2] = '{4'b0001, 1'b1, 3'd0, 8'h01};
        tbl[3] = '{4'b0011, 1'b1, 3'd1, 8'h02};
        tbl[4] = '{4'b0101, 1'b1, 3'd2, 8'h04};
        tbl[5] = '{4'b0101, 1'b0, 3'd2, 8'h00};
        tbl[6] = '{4'b1110, 1'b0, 3'd2, 8'h00};
        tbl[7] = '{4'b1100, 1'b1, 3'd5, 8'h20};
        tbl[8] = '{4'b1000, 1'b1, 3'd6, 8'h40};
        tbl[9] = '{4'b0000, 1'b1, 3'd7, 8'h80};

        // Reset values and decode latency / illegal-code table.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].q, 1'b0);
            chk($sformatf("tbl%0d_valid", i),  32'(valid_o),        32'(tbl[i].v));
            chk($sformatf("tbl%0d_phase", i),  32'(phase_o),        32'(tbl[i].ph));
            chk($sformatf("tbl%0d_onehot", i), 32'(phase_onehot_o), 32'(tbl[i].oh));
            chk($sformatf("tbl%0d_locked", i), 32'(locked_o),       32'd0);
        end

        // Clean sequence: lock on the 10th edge, first revolution on the 18th.
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            step(jc((e - 1) % 8), 1'b0);
            if (e == 9)  chk("lock_e9",  32'(locked_o), 32'd0);
            if (e == 10) chk("lock_e10", 32'(locked_o), 32'd1);
            if (e == 17) chk("pulse_e17", 32'(rev_pulse_o), 32'd0);
            if (e == 18) begin
                chk("pulse_e18", 32'(rev_pulse_o), 32'd1);
                chk("rev_e18",   32'(rev_count_o), 32'd1);
            end
            if (e == 19) chk("pulse_e19", 32'(rev_pulse_o), 32'd0);
        end
        ph = 20;

        // Illegal code while locked -> FAULT, held until clr_err.
        step(4'b0101, 1'b0);
        chk("ill_still_locked", 32'(locked_o), 32'd1);
        step(jc(ph % 8), 1'b0); ph++;
        chk("ill_valid",  32'(valid_o),        32'd0);
        chk("ill_onehot", 32'(phase_onehot_o), 32'd0);
        chk("ill_locked", 32'(locked_o),       32'd0);
        chk("ill_err",    32'(err_sticky_o),   32'd1);
        for (int i = 0; i < 16; i++) begin step(jc(ph % 8), 1'b0); ph++; end
        chk("fault_hold_locked", 32'(locked_o),     32'd0);
        chk("fault_hold_err",    32'(err_sticky_o), 32'd1);
        step(jc(ph % 8), 1'b1); ph++;
        chk("clr_err", 32'(err_sticky_o), 32'd0);
        step(jc(ph % 8), 1'b0); ph++;
        async_reset_check("areset1");

        // Skip 0001 -> 0111 while locked.
        do_reset();
        for (int e = 0; e < 20; e++) step(jc(e % 8), 1'b0);
        ph = 20;
        while (ph % 8 != 1) begin step(jc(ph % 8), 1'b0); ph++; end
        step(jc(1), 1'b0);
        step(4'b0111, 1'b0);
        chk("skip_lock_pre", 32'(locked_o), 32'd1);
        step(jc(4), 1'b0);
        chk("skip_lock_locked", 32'(locked_o),     32'd0);
        chk("skip_lock_err",    32'(err_sticky_o), 32'd1);

        // Same skip while tracking -> back to SEARCH, then a fresh lock run.
        do_reset();
        step(jc(0), 1'b0);
        step(jc(1), 1'b0);
        step(4'b0111, 1'b0);
        step(jc(4), 1'b0);
        chk("skip_track_err", 32'(err_sticky_o), 32'd0);
        for (int e = 5; e <= 13; e++) begin
            step(jc(e % 8), 1'b0);
            if (e == 12) chk("relock_e12", 32'(locked_o), 32'd0);
            if (e == 13) chk("relock_e13", 32'(locked_o), 32'd1);
        end
        chk("skip_track_err_end", 32'(err_sticky_o), 32'd0);

        // Revolution counter wrap after 256 revolutions.
        do_reset();
        for (int e = 1; e <= 2058; e++) begin
            step(jc((e - 1) % 8), 1'b0);
            if (e == 2050) begin
                chk("rev_255",     32'(rev_count_o), 32'd255);
                chk("pulse_255",   32'(rev_pulse_o), 32'd1);
            end
            if (e == 2058) begin
                chk("rev_wrap",    32'(rev_count_o), 32'd0);
                chk("pulse_wrap",  32'(rev_pulse_o), 32'd1);
            end
        end

        // clr_err coinciding with a BAD transition in LOCKED: the error wins.
        step(4'b0101, 1'b0);
        step(jc(2), 1'b1);
        chk("clr_vs_bad_locked", 32'(locked_o),     32'd0);
        chk("clr_vs_bad_err",    32'(err_sticky_o), 32'd1);
        step(jc(3), 1'b0);
        chk("clr_vs_bad_hold", 32'(err_sticky_o), 32'd1);
        async_reset_check("areset2");

        // Randomized stimulus against the model.
        do_reset();
        ph = 0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 75)      begin ph = (ph + 1) % 8; c = jc(ph); end
            else if (r < 85) c = jc(ph);
            else if (r < 90) begin ph = (ph + 2) % 8; c = jc(ph); end
            else begin
                c = 4'(($urandom_range(0, 15)));
                for (int t = 0; t < 32 && code_phase(c) >= 0 && r < 95; t++)
                    c = 4'(($urandom_range(0, 15)));
                if (code_phase(c) >= 0) ph = code_phase(c);
            end
            step(c, ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
